muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 25 ++
 rtl/muldiv_sign_fix.sv | 46 ++++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared CPU package: multiply/divide op encodings, FSM states and op decode helpers.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude conversion on entry and result sign correction on exit,
// shared by multiply and divide so both use one unsigned datapath.
module muldiv_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_neg_q,
  output logic             o_neg_r,
  input  logic             i_is_div,
  input  logic             i_neg_q,
  input  logic             i_neg_r,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  always_comb begin
    o_mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    o_mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    o_neg_q = i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    o_neg_r = i_signed && i_a[WIDTH-1];
  end

  always_comb begin
    w_prod     = {i_hi, i_lo};
    w_prod_fix = i_neg_q ? -w_prod : w_prod;
    if (i_is_div) begin
      o_hi = i_neg_r ? -i_hi : i_hi;
      o_lo = i_neg_q ? -i_lo : i_lo;
    end else begin
      o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      o_lo = w_prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with abort and divide-by-zero fast path.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  op_e              r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_opb;
  logic             r_neg_q;
  logic             r_neg_r;

  op_e              w_op_in;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_neg_q, w_neg_r;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_acc_nx, w_q_nx;
  logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

  assign w_op_in = op_e'(op);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_signed (op_is_signed(w_op_in)),
    .i_a      (a),
    .i_b      (b),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_neg_q  (w_neg_q),
    .o_neg_r  (w_neg_r),
    .i_is_div (op_is_div(r_op)),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .i_hi     (w_acc_nx),
    .i_lo     (w_q_nx),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // One iteration: r_acc is product-high / partial remainder, r_q is multiplier / quotient.
  always_comb begin
    w_addend = r_q[0] ? r_opb : '0;
    w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
    w_rem_sh = {r_acc, r_q[WIDTH-1]};
    w_diff   = w_rem_sh[WIDTH-1:0] - r_opb;
    w_acc_nx = w_sum[WIDTH:1];
    w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
    if (op_is_div(r_op)) begin
      if (w_rem_sh >= {1'b0, r_opb}) begin
        w_acc_nx = w_diff;
        w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nx = w_rem_sh[WIDTH-1:0];
        w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Last iteration and sign fix share an edge so the corrected result is visible throughout FIN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MULT;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= w_op_in;
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
            r_cnt   <= '0;
            r_acc   <= '0;
            busy    <= 1'b1;
            if (op_is_div(w_op_in) && (b == '0)) begin
              r_state  <= ST_FIN;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_q     <= op_is_div(w_op_in) ? w_mag_a : w_mag_b;
              r_opb   <= op_is_div(w_op_in) ? w_mag_b : w_mag_a;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_state <= ST_FIN;
              done    <= 1'b1;
              hi      <= w_fix_hi;
              lo      <= w_fix_lo;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): transaction-level timeline model with
// arithmetic reference, per-cycle output compare, directed literal cases and random ops.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_errs   = 0;
  logic chk_en = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .abort(abort),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      2'b10: begin
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Timeline model: accepted op completes W edges later (div-by-zero immediately).
  int          n_edge = 0;
  int          m_end  = -1;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_end <= -1;
    end else begin
      n_edge <= n_edge + 1;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_end >= 0) begin
        if ((n_edge + 1) > m_end || abort) begin
          m_busy <= 1'b0;
          m_end  <= -1;
        end else if ((n_edge + 1) == m_end) begin
          m_done <= 1'b1;
          {m_hi, m_lo} <= m_res;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        if (op[1] && b == '0) begin
          m_done <= 1'b1;
          m_dz   <= 1'b1;
          m_end  <= n_edge + 1;
        end else begin
          m_res <= ref_result(op, a, b);
          m_end <= n_edge + 1 + W;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic ab);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1; abort = ab;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, ndone, k;
    logic [1:0]  o;
    logic [31:0] x, y;
    logic        is_dz;

    reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;

    chk("pin_model_mult",  ref_result(2'b00, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("pin_model_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("pin_model_div",   ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_model_minneg", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_done(lat);
    chk("mult_lat", 64'(lat), 64'd33);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(lat);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    wait_done(lat);
    chk("divu_b2b_lat", 64'(lat), 64'd33);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);

    issue(2'b11, 32'd55, 32'd0, 1'b0);
    wait_done(lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_flag", 64'(div_zero), 64'd1);
    chk("dz_hi", 64'(hi), 64'd2);
    chk("dz_lo", 64'(lo), 64'd14);
    wait_idle();

    // Abort at iteration 10 with a stray start during RUN.
    issue(2'b00, 32'd1234, 32'd5678, 1'b0);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("abort_hi", 64'(hi), 64'd2);
    chk("abort_lo", 64'(lo), 64'd14);

    // Asynchronous reset mid-divide.
    issue(2'b10, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_dz", 64'(div_zero), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_lo", 64'(lo), 64'd12);
    chk("post_rst_hi", 64'(hi), 64'd0);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat);
    chk("minneg_lo", 64'(lo), 64'h8000_0000);
    chk("minneg_hi", 64'(hi), 64'd0);
    chk("minneg_dz", 64'(div_zero), 64'd0);

    issue(2'b01, 32'd5, 32'd6, 1'b1);
    wait_done(lat);
    chk("start_abort_idle_lat", 64'(lat), 64'd33);
    chk("start_abort_idle_lo", 64'(lo), 64'd30);

    for (int i = 0; i < 60; i++) begin
      wait_idle();
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      is_dz = o[1] && (y == 0);
      issue(o, x, y, ($urandom_range(0, 7) == 0));
      if (!is_dz && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 30);
        repeat (k - 1) @(negedge clock);
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        @(negedge clock);
        start = 1'b0; abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
      end else begin
        wait_done(lat);
        chk("rand_lat", 64'(lat), is_dz ? 64'd1 : 64'd33);
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_idle();
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
